// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer (TIMA/TMA/TAC).
// Build option: TIMER_GLITCH_EN (see timer_tick_sel) changes tick generation only.
package timer_pkg;

  typedef enum logic [1:0] {
    TST_RUN,
    TST_OVF,
    TST_RELOAD
  } timer_state_t;

  // TAC[1:0] clock select, named by the resulting TIMA increment rate
  typedef enum logic [1:0] {
    TAC_4096,
    TAC_262144,
    TAC_65536,
    TAC_16384
  } tac_clk_t;

  // Unimplemented TAC bits read back as ones
  localparam logic [7:0] TAC_RD_MASK = 8'hF8;

endpackage

// File: rtl/timer_ctrl_if.sv
// CPU register bus for the timer: address decodes, strobes and data.
// The CPU side uses master, the timer uses slave.
interface timer_ctrl_if;

  logic       sel_tima;
  logic       sel_tma;
  logic       sel_tac;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output sel_tima, sel_tma, sel_tac, cpu_wr, cpu_rd, d_in,
    input  d_out, d_oe
  );

  modport slave (
    input  sel_tima, sel_tma, sel_tac, cpu_wr, cpu_rd, d_in,
    output d_out, d_oe
  );

endinterface

// File: rtl/timer_tick_sel.sv
// Divider tap select and falling-edge detect producing the TIMA increment tick.
// TIMER_GLITCH_EN defined: the enable is folded into the sampled signal, so
//   disabling the timer or switching taps while the tap is high makes a tick.
// TIMER_GLITCH_EN undefined: ticks are gated by the enable and suppressed in
//   the clk after a TAC write, so TAC writes never make ticks.
module timer_tick_sel
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] div_tap,
  input  logic [2:0] tac,
  input  logic       tac_wr,
  output logic       tick
);

  logic tap_sel;
  logic tsig;
  logic tsig_q;

  // Pick the divider tap named by TAC[1:0]
  always_comb begin
    tap_sel = div_tap[0];
    case (tac_clk_t'(tac[1:0]))
      TAC_4096:   tap_sel = div_tap[0];
      TAC_262144: tap_sel = div_tap[1];
      TAC_65536:  tap_sel = div_tap[2];
      TAC_16384:  tap_sel = div_tap[3];
      default:    tap_sel = div_tap[0];
    endcase
  end

`ifdef TIMER_GLITCH_EN
  logic unused_tac_wr;
  assign unused_tac_wr = tac_wr;
  assign tsig          = tap_sel & tac[2];

  // Edge history of the gated tap
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) tsig_q <= 1'b0;
    else         tsig_q <= tsig;
  end

  assign tick = tsig_q & ~tsig;
`else
  logic tac_wr_q;
  assign tsig = tap_sel;

  // Edge history of the raw tap, plus a marker for the clk after a TAC write
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tsig_q   <= 1'b0;
      tac_wr_q <= 1'b0;
    end else begin
      tsig_q   <= tsig;
      tac_wr_q <= tac_wr;
    end
  end

  assign tick = tsig_q & ~tsig & tac[2] & ~tac_wr_q;
`endif

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: TIMA/TMA/TAC registers, overflow/reload sequencing and
// a one-clk interrupt pulse in the reload cycle.
// Build option: TIMER_GLITCH_EN (passed through to timer_tick_sel).
//
//   state       | meaning
//   TST_RUN     | TIMA counts ticks
//   TST_OVF     | TIMA overflowed, reads 00, waiting out the reload delay
//   TST_RELOAD  | one clk: TIMA <= TMA, irq_timer high
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int RELOAD_DELAY = 4
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [3:0]         div_tap,
  timer_ctrl_if.slave        bus,
  output logic               irq_timer
);

  localparam int DLY_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;

  timer_state_t state, state_nxt;
  logic [7:0]       tima, tima_nxt;
  logic [7:0]       tma;
  logic [2:0]       tac;
  logic [DLY_W-1:0] dly, dly_nxt;
  logic             irq_nxt;
  logic             tick;
  logic             wr_tima, wr_tma, wr_tac;
  logic [7:0]       tma_eff;

  assign wr_tima = bus.sel_tima & bus.cpu_wr;
  assign wr_tma  = bus.sel_tma  & bus.cpu_wr;
  assign wr_tac  = bus.sel_tac  & bus.cpu_wr;
  // A TMA write in the reload cycle must be the value that lands in TIMA
  assign tma_eff = wr_tma ? bus.d_in : tma;

  timer_tick_sel u_tick_sel (
    .clk     (clk),
    .nreset  (nreset),
    .div_tap (div_tap),
    .tac     (tac),
    .tac_wr  (wr_tac),
    .tick    (tick)
  );

  // TMA and TAC are plain CPU-written registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma) tma <= bus.d_in;
      if (wr_tac) tac <= bus.d_in[2:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= TST_RUN;
    else         state <= state_nxt;
  end

  // Next-state: overflow entry, reload delay expiry, CPU cancel from OVF
  always_comb begin
    state_nxt = state;
    case (state)
      TST_RUN: begin
        if (!wr_tima && tick && (tima == 8'hFF))
          state_nxt = (RELOAD_DELAY == 1) ? TST_RELOAD : TST_OVF;
      end
      TST_OVF: begin
        if (wr_tima)       state_nxt = TST_RUN;
        else if (dly == '0) state_nxt = TST_RELOAD;
      end
      TST_RELOAD: state_nxt = TST_RUN;
      default:    state_nxt = TST_RUN;
    endcase
  end

  // Outputs of the FSM: TIMA update, delay counter and interrupt request
  always_comb begin
    tima_nxt = tima;
    dly_nxt  = dly;
    irq_nxt  = (state_nxt == TST_RELOAD);
    case (state)
      TST_RUN: begin
        if (wr_tima) begin
          tima_nxt = bus.d_in;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_nxt = 8'h00;
            dly_nxt  = DLY_W'(RELOAD_DELAY - 1);
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      TST_OVF: begin
        if (wr_tima)         tima_nxt = bus.d_in;
        else if (dly != '0)  dly_nxt  = dly - DLY_W'(1);
      end
      TST_RELOAD: tima_nxt = tma_eff;
      default:    tima_nxt = tima;
    endcase
  end

  // TIMA, delay counter and registered interrupt
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima      <= 8'h00;
      dly       <= '0;
      irq_timer <= 1'b0;
    end else begin
      tima      <= tima_nxt;
      dly       <= dly_nxt;
      irq_timer <= irq_nxt;
    end
  end

  assign bus.d_oe = bus.cpu_rd & (bus.sel_tima | bus.sel_tma | bus.sel_tac);

  // Combinational read mux, no side effects
  always_comb begin
    bus.d_out = 8'h00;
    if (bus.sel_tima)     bus.d_out = tima;
    else if (bus.sel_tma) bus.d_out = tma;
    else if (bus.sel_tac) bus.d_out = TAC_RD_MASK | {5'b00000, tac};
  end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] div_tap;
  logic       irq_timer;

  timer_ctrl_if bus ();

  timer_ctrl dut (
    .clk       (clk),
    .nreset    (nreset),
    .div_tap   (div_tap),
    .bus       (bus),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic [7:0] base;
  logic [7:0] g_inc;

  localparam logic [1:0] A_TIMA = 2'd0;
  localparam logic [1:0] A_TMA  = 2'd1;
  localparam logic [1:0] A_TAC  = 2'd2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %02h expected queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: got %02h expected %02h", e.tag, obs, e.val);
      end
    end
  endtask

  // Called at a negedge; the write lands on the next posedge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.sel_tima = (a == A_TIMA);
    bus.sel_tma  = (a == A_TMA);
    bus.sel_tac  = (a == A_TAC);
    bus.cpu_wr   = 1'b1;
    bus.d_in     = d;
    @(negedge clk);
    bus.sel_tima = 1'b0;
    bus.sel_tma  = 1'b0;
    bus.sel_tac  = 1'b0;
    bus.cpu_wr   = 1'b0;
  endtask

  // Combinational read inside the low phase; does not advance the clock.
  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    bus.sel_tima = (a == A_TIMA);
    bus.sel_tma  = (a == A_TMA);
    bus.sel_tac  = (a == A_TAC);
    bus.cpu_rd   = 1'b1;
    #1;
    v = bus.d_out;
    bus.cpu_rd   = 1'b0;
    bus.sel_tima = 1'b0;
    bus.sel_tma  = 1'b0;
    bus.sel_tac  = 1'b0;
  endtask

  task automatic chk_rd(input logic [1:0] a);
    logic [7:0] v;
    rd(a, v);
    check(v);
  endtask

  task automatic chk_irq();
    check({7'b0, irq_timer});
  endtask

  // One falling edge on tap 1; returns at the negedge after the tick edge.
  task automatic pulse1();
    div_tap[1] = 1'b1;
    @(negedge clk);
    div_tap[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    nreset       = 1'b0;
    div_tap      = 4'h0;
    bus.sel_tima = 1'b0;
    bus.sel_tma  = 1'b0;
    bus.sel_tac  = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_rd   = 1'b0;
    bus.d_in     = 8'h00;
`ifdef TIMER_GLITCH_EN
    g_inc = 8'd1;
`else
    g_inc = 8'd0;
`endif
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // reset state
    push("rst_tima", 8'h00); chk_rd(A_TIMA);
    push("rst_tma",  8'h00); chk_rd(A_TMA);
    push("rst_tac",  8'hF8); chk_rd(A_TAC);
    push("rst_irq",  8'h00); chk_irq();
    push("rst_oe_idle", 8'h00); check({7'b0, bus.d_oe});

    // counting on tap 1
    wr(A_TAC, 8'h05);
    wr(A_TIMA, 8'h00);
    push("tac_rd_05", 8'hFD); chk_rd(A_TAC);
    push("count_10", 8'h0A);
    for (int i = 0; i < 10; i++) pulse1();
    chk_rd(A_TIMA);

    // disabled: no counting
    wr(A_TAC, 8'h01);
    push("disabled_hold", 8'h0A);
    for (int i = 0; i < 3; i++) pulse1();
    chk_rd(A_TIMA);

    // glitch: disable while selected tap high
    wr(A_TAC, 8'h05);
    div_tap[1] = 1'b1;
    @(negedge clk);
    base = 8'h0A;
    push("glitch_disable", base + g_inc);
    wr(A_TAC, 8'h01);
    @(negedge clk);
    chk_rd(A_TIMA);
    div_tap[1] = 1'b0;
    @(negedge clk);

    // glitch: switch tap while selected tap high
    base = base + g_inc;
    wr(A_TAC, 8'h05);
    div_tap[1] = 1'b1;
    @(negedge clk);
    push("glitch_switch", base + g_inc);
    wr(A_TAC, 8'h06);
    @(negedge clk);
    chk_rd(A_TIMA);
    div_tap[1] = 1'b0;
    @(negedge clk);

    // overflow and delayed reload
    wr(A_TAC, 8'h05);
    wr(A_TMA, 8'hC0);
    wr(A_TIMA, 8'hFF);
    pulse1();
    for (int i = 1; i <= 4; i++) begin
      push("ovf_tima_zero", 8'h00);
      push("ovf_irq_low", 8'h00);
    end
    push("reload_irq", 8'h01);
    push("after_reload_tima", 8'hC0);
    push("after_reload_irq", 8'h00);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      chk_rd(A_TIMA);
      chk_irq();
    end
    @(negedge clk);
    chk_irq();
    @(negedge clk);
    chk_rd(A_TIMA);
    chk_irq();

    // cancel reload by writing TIMA in OVF clk 2
    wr(A_TIMA, 8'hFF);
    pulse1();
    wr(A_TIMA, 8'h55);
    for (int i = 0; i < 6; i++) begin
      push("cancel_irq", 8'h00);
      chk_irq();
      @(negedge clk);
    end
    push("cancel_tima", 8'h55); chk_rd(A_TIMA);

    // TIMA write coincident with tick at FF: write wins, no overflow
    wr(A_TIMA, 8'hFF);
    div_tap[1] = 1'b1;
    @(negedge clk);
    div_tap[1] = 1'b0;
    wr(A_TIMA, 8'h30);
    for (int i = 0; i < 6; i++) begin
      push("wr_tick_irq", 8'h00);
      chk_irq();
      @(negedge clk);
    end
    push("wr_tick_tima", 8'h30); chk_rd(A_TIMA);

    // TMA write in the reload cycle lands in TIMA
    wr(A_TIMA, 8'hFF);
    pulse1();
    repeat (4) @(negedge clk);
    push("rl_tma_irq", 8'h01); chk_irq();
    wr(A_TMA, 8'h77);
    push("rl_tma_tima", 8'h77); chk_rd(A_TIMA);
    push("rl_tma_tma",  8'h77); chk_rd(A_TMA);

    // TIMA write in the reload cycle is ignored
    wr(A_TIMA, 8'hFF);
    pulse1();
    repeat (4) @(negedge clk);
    push("rl_tima_irq", 8'h01); chk_irq();
    wr(A_TIMA, 8'h12);
    push("rl_tima_ignored", 8'h77); chk_rd(A_TIMA);

    // async reset in the middle of OVF
    wr(A_TIMA, 8'hFF);
    pulse1();
    @(negedge clk);
    nreset = 1'b0;
    #2;
    nreset = 1'b1;
    push("mid_rst_tima", 8'h00); chk_rd(A_TIMA);
    push("mid_rst_tma",  8'h00); chk_rd(A_TMA);
    push("mid_rst_tac",  8'hF8); chk_rd(A_TAC);
    for (int i = 0; i < 8; i++) begin
      push("mid_rst_irq", 8'h00);
      chk_irq();
      @(negedge clk);
    end
    push("mid_rst_tima_end", 8'h00); chk_rd(A_TIMA);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
